cte_sched: RTL and testbench

Scheduler that shares one CTE colour-transform core between two requesters: channel A streams RGB pixels for RGB→YUV 4:2:2 (op_mode 1), and channel B streams U,Y,V,Y samples for YUV→RGB (op_mode 0). It sits directly in front of the CTE instance and does four things:
- grants the core to one channel at a time, round-robin, in whole-group bursts;
- drains the core pipeline and switches op_mode between grants;
- gates input against the core's busy;
- routes core outputs back to the owning channel.

---
 rtl/cte_sched.sv | 198 +++++++++++++++++++
 tb/tb_cte_sched.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cte_sched.sv
// rtl/cte_sched.sv - round-robin scheduler sharing one CTE colour-transform core between an RGB and a YUV requester
//
// Channel A streams RGB pixels for RGB->YUV 4:2:2 (core mode 1).
// Channel B streams U,Y,V,Y samples for YUV->RGB (core mode 0).
// The core is granted to one channel at a time, in whole-group bursts.
// Between grants the core pipeline is drained and the core mode is switched.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   a_req/a_rgb/a_ready   channel A pixel input handshake
//   a_yuv/a_yuv_valid     channel A result bytes
//   b_req/b_yuv/b_ready   channel B sample input handshake
//   b_rgb/b_rgb_valid     channel B result pixels
//   cte_*                 connection to the shared CTE core
//   grant                 current owner: 00 none, 01 A, 10 B
//   err                   sticky protocol / drain-timeout error
module cte_sched #(
  parameter int BURST     = 8,
  parameter int DRAIN_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic [23:0] a_rgb,
  output logic        a_ready,
  output logic [7:0]  a_yuv,
  output logic        a_yuv_valid,
  input  logic        b_req,
  input  logic [7:0]  b_yuv,
  output logic        b_ready,
  output logic [23:0] b_rgb,
  output logic        b_rgb_valid,
  output logic        cte_op_mode,
  output logic        cte_in_en,
  output logic [23:0] cte_rgb_in,
  output logic [7:0]  cte_yuv_in,
  input  logic        cte_busy,
  input  logic        cte_out_valid,
  input  logic [23:0] cte_rgb_out,
  input  logic [7:0]  cte_yuv_out,
  output logic [1:0]  grant,
  output logic        err
);

  localparam int PW = $clog2(4 * BURST + 1);
  localparam int GW = $clog2(BURST + 1);
  localparam int TW = $clog2(DRAIN_MAX + 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(4 * BURST);

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_RUN, S_DRAIN} state_t;

  state_t        state_q, state_nxt;
  logic [1:0]    grant_q, grant_nxt;
  logic          op_q, op_nxt;
  logic          last_b_q, last_b_nxt;   // 1: B was served last, so A wins a tie
  logic [1:0]    samp_q, samp_nxt;
  logic [GW-1:0] grp_q, grp_nxt;
  logic [PW-1:0] pend_q, pend_nxt;
  logic [TW-1:0] tmr_q, tmr_nxt;
  logic          err_q, err_nxt;

  logic          own_a, own_b, own_req, in_run, in_busy_state;
  logic          a_acc, b_acc, in_acc, out_ok;
  logic          pick_a, pend_add;
  logic [1:0]    samp_last;
  logic [PW:0]   pend_sum;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      grant_q  <= 2'b00;
      op_q     <= 1'b0;
      last_b_q <= 1'b1;
      samp_q   <= 2'd0;
      grp_q    <= '0;
      pend_q   <= '0;
      tmr_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      grant_q  <= grant_nxt;
      op_q     <= op_nxt;
      last_b_q <= last_b_nxt;
      samp_q   <= samp_nxt;
      grp_q    <= grp_nxt;
      pend_q   <= pend_nxt;
      tmr_q    <= tmr_nxt;
      err_q    <= err_nxt;
    end
  end

  // Output / datapath decode
  always_comb begin
    own_a         = (grant_q == 2'b01);
    own_b         = (grant_q == 2'b10);
    own_req       = own_a ? a_req : b_req;
    in_run        = (state_q == S_RUN);
    in_busy_state = (state_q == S_RUN) || (state_q == S_DRAIN);

    a_ready   = in_run && own_a && !cte_busy;
    b_ready   = in_run && own_b && !cte_busy;
    a_acc     = a_req && a_ready;
    b_acc     = b_req && b_ready;
    in_acc    = a_acc || b_acc;
    cte_in_en = in_acc;

    cte_rgb_in = (in_run && own_a) ? a_rgb : 24'd0;
    cte_yuv_in = (in_run && own_b) ? b_yuv : 8'd0;

    // A result that nobody is waiting for is swallowed here and flagged via err.
    out_ok      = cte_out_valid && in_busy_state && (pend_q != '0);
    a_yuv_valid = out_ok && own_a;
    b_rgb_valid = out_ok && own_b;
    a_yuv       = a_yuv_valid ? cte_yuv_out : 8'd0;
    b_rgb       = b_rgb_valid ? cte_rgb_out : 24'd0;

    cte_op_mode = op_q;
    grant       = grant_q;
    err         = err_q;
  end

  // Next-state logic
  always_comb begin
    state_nxt  = state_q;
    grant_nxt  = grant_q;
    op_nxt     = op_q;
    last_b_nxt = last_b_q;
    samp_nxt   = samp_q;
    grp_nxt    = grp_q;
    tmr_nxt    = tmr_q;
    err_nxt    = err_q;
    pick_a     = 1'b0;
    samp_last  = own_a ? 2'd1 : 2'd3;

    // Each A pixel yields two result bytes; each full B group yields two pixels.
    pend_add = a_acc || (b_acc && (samp_q == 2'd3));
    pend_sum = {1'b0, pend_q} + (pend_add ? (PW+1)'(2) : (PW+1)'(0)) - (PW+1)'(out_ok);
    if (pend_sum > {1'b0, PEND_MAX}) pend_nxt = PEND_MAX;
    else                             pend_nxt = pend_sum[PW-1:0];

    if (cte_out_valid && !out_ok) err_nxt = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (a_req || b_req) begin
          pick_a    = a_req && (!b_req || last_b_q);
          grant_nxt = pick_a ? 2'b01 : 2'b10;
          // A needs mode 1 and B mode 0, so the mode equals pick_a.
          state_nxt = (pick_a != op_q) ? S_SWITCH : S_RUN;
        end
      end
      S_SWITCH: begin
        op_nxt    = own_a;
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (in_acc) begin
          if (samp_q == samp_last) begin
            samp_nxt = 2'd0;
            grp_nxt  = grp_q + GW'(1);
            if (grp_q == GW'(BURST - 1)) state_nxt = S_DRAIN;
          end else begin
            samp_nxt = samp_q + 2'd1;
          end
        end else if (!own_req && (samp_q == 2'd0)) begin
          // Only release on a group boundary; mid-group the grant is held.
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pend_nxt == '0) begin
          state_nxt  = S_IDLE;
          last_b_nxt = own_b;
          grant_nxt  = 2'b00;
          samp_nxt   = 2'd0;
          grp_nxt    = '0;
          tmr_nxt    = '0;
        end else if (cte_out_valid) begin
          tmr_nxt = '0;
        end else if (tmr_q == TW'(DRAIN_MAX - 1)) begin
          err_nxt    = 1'b1;
          pend_nxt   = '0;
          state_nxt  = S_IDLE;
          last_b_nxt = own_b;
          grant_nxt  = 2'b00;
          samp_nxt   = 2'd0;
          grp_nxt    = '0;
          tmr_nxt    = '0;
        end else begin
          tmr_nxt = tmr_q + TW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cte_sched.sv
// tb/tb_cte_sched.sv - randomized self-checking bench for cte_sched with a behavioural CTE core model
module tb_cte_sched;

  localparam int BURST     = 8;
  localparam int DRAIN_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_ready, a_yuv_valid;
  logic [23:0] a_rgb;
  logic [7:0]  a_yuv;
  logic        b_req, b_ready, b_rgb_valid;
  logic [7:0]  b_yuv;
  logic [23:0] b_rgb;
  logic        cte_op_mode, cte_in_en, cte_busy, cte_out_valid;
  logic [23:0] cte_rgb_in, cte_rgb_out;
  logic [7:0]  cte_yuv_in, cte_yuv_out;
  logic [1:0]  grant;
  logic        err;

  cte_sched #(.BURST(BURST), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_rgb(a_rgb), .a_ready(a_ready), .a_yuv(a_yuv), .a_yuv_valid(a_yuv_valid),
    .b_req(b_req), .b_yuv(b_yuv), .b_ready(b_ready), .b_rgb(b_rgb), .b_rgb_valid(b_rgb_valid),
    .cte_op_mode(cte_op_mode), .cte_in_en(cte_in_en), .cte_rgb_in(cte_rgb_in), .cte_yuv_in(cte_yuv_in),
    .cte_busy(cte_busy), .cte_out_valid(cte_out_valid), .cte_rgb_out(cte_rgb_out), .cte_yuv_out(cte_yuv_out),
    .grant(grant), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural transform used both by the core model and the expectation queues.
  function automatic logic [7:0] a_byte(input logic [23:0] p, input int k);
    return (k == 0) ? (p[23:16] ^ p[7:0]) : (p[15:8] + 8'd1);
  endfunction

  function automatic logic [23:0] b_pix(input logic [7:0] s0, input logic [7:0] s1,
                                        input logic [7:0] s2, input logic [7:0] s3, input int k);
    return (k == 0) ? {s0, s1, s2} : ({s3, s1, s2} ^ 24'h5a5a5a);
  endfunction

  // Requester modes: 0 off, 1 always, 2 random, 3 counted, 4 finish current group
  int a_mode = 0, b_mode = 0, busy_mode = 0;
  int a_left = 0, b_left = 0, busy_cnt = 0;
  bit core_hold = 1'b0;
  int a_acc, b_acc, a_val, b_val, viol, busy_lo, core_gap;
  logic [7:0]  exp_a[$];
  logic [23:0] exp_b[$];
  logic [7:0]  bsamp[$];
  logic [7:0]  csamp[$];
  logic [31:0] cq[$];
  logic [1:0]  glog[$];
  int          gacc[$];
  logic [1:0]  prev_grant = 2'b00;

  task automatic clr_counts();
    a_acc = 0; b_acc = 0; a_val = 0; b_val = 0; busy_lo = 0;
    glog.delete(); gacc.delete();
  endtask

  // Monitor, scoreboard, core model and input drivers
  initial begin
    logic acc_a, acc_b;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      acc_a = 1'b0; acc_b = 1'b0;
      if (reset) begin
        acc_a = a_req && a_ready;
        acc_b = b_req && b_ready;
        if (grant != prev_grant && grant != 2'b00) begin
          glog.push_back(grant);
          gacc.push_back(0);
        end
        prev_grant = grant;
        if (a_ready && b_ready) viol++;
        if (cte_busy && (a_ready || b_ready)) viol++;
        if (cte_in_en && !acc_a && !acc_b) viol++;
        if (cte_busy && !a_ready) busy_lo++;
        if (acc_a) begin
          a_acc++;
          if (cte_op_mode !== 1'b1) viol++;
          check("a_in_en", 32'(cte_in_en), 32'd1);
          check("a_in_data", 32'(cte_rgb_in), 32'(a_rgb));
          exp_a.push_back(a_byte(a_rgb, 0));
          exp_a.push_back(a_byte(a_rgb, 1));
          if (gacc.size() > 0) gacc[gacc.size()-1]++;
        end
        if (acc_b) begin
          b_acc++;
          if (cte_op_mode !== 1'b0) viol++;
          check("b_in_en", 32'(cte_in_en), 32'd1);
          check("b_in_data", 32'(cte_yuv_in), 32'(b_yuv));
          bsamp.push_back(b_yuv);
          if (bsamp.size() == 4) begin
            exp_b.push_back(b_pix(bsamp[0], bsamp[1], bsamp[2], bsamp[3], 0));
            exp_b.push_back(b_pix(bsamp[0], bsamp[1], bsamp[2], bsamp[3], 1));
            bsamp.delete();
          end
          if (gacc.size() > 0) gacc[gacc.size()-1]++;
        end
        if (a_yuv_valid) begin
          a_val++;
          if (b_rgb_valid) viol++;
          if (exp_a.size() == 0) check("a_out_extra", 32'd1, 32'd0);
          else check("a_out_data", 32'(a_yuv), 32'(exp_a.pop_front()));
        end
        if (b_rgb_valid) begin
          b_val++;
          if (exp_b.size() == 0) check("b_out_extra", 32'd1, 32'd0);
          else check("b_out_data", 32'(b_rgb), 32'(exp_b.pop_front()));
        end
        // Core model consumes what the scheduler strobes into it.
        if (cte_in_en) begin
          if (cte_op_mode) begin
            cq.push_back(32'(a_byte(cte_rgb_in, 0)));
            cq.push_back(32'(a_byte(cte_rgb_in, 1)));
          end else begin
            csamp.push_back(cte_yuv_in);
            if (csamp.size() == 4) begin
              cq.push_back(32'(b_pix(csamp[0], csamp[1], csamp[2], csamp[3], 0)));
              cq.push_back(32'(b_pix(csamp[0], csamp[1], csamp[2], csamp[3], 1)));
              csamp.delete();
            end
          end
        end
      end

      @(posedge clk);
      #1;
      if (!reset) begin
        exp_a.delete(); exp_b.delete(); bsamp.delete(); csamp.delete(); cq.delete();
        prev_grant = 2'b00; core_gap = 0;
        cte_out_valid = 1'b0; cte_rgb_out = 24'd0; cte_yuv_out = 8'd0;
        a_req = 1'b0; b_req = 1'b0; cte_busy = 1'b0;
      end else begin
        cte_out_valid = 1'b0;
        if (!core_hold && cq.size() > 0 && (core_gap >= 3 || $urandom_range(0, 2) != 0)) begin
          e = cq.pop_front();
          cte_out_valid = 1'b1;
          cte_rgb_out = e[23:0];
          cte_yuv_out = e[7:0];
          core_gap = 0;
        end else begin
          core_gap++;
        end
        if (acc_a) begin a_rgb = 24'($urandom); if (a_left > 0) a_left--; end
        if (acc_b) begin b_yuv = 8'($urandom);  if (b_left > 0) b_left--; end
        case (a_mode)
          0: a_req = 1'b0;
          1: a_req = 1'b1;
          2: a_req = ($urandom_range(0, 3) != 0);
          3: a_req = (a_left > 0);
          default: a_req = ((a_acc % 2) != 0);
        endcase
        case (b_mode)
          0: b_req = 1'b0;
          1: b_req = 1'b1;
          2: b_req = ($urandom_range(0, 3) != 0);
          3: b_req = (b_left > 0);
          default: b_req = ((b_acc % 4) != 0);
        endcase
        case (busy_mode)
          1: cte_busy = ($urandom_range(0, 4) == 0);
          2: begin
            if (busy_cnt > 0) begin cte_busy = 1'b1; busy_cnt--; end
            else cte_busy = 1'b0;
          end
          default: cte_busy = 1'b0;
        endcase
      end
    end
  end

  task automatic wait_cnt(input string tag, input int which, input int n, input int max);
    int k = 0;
    while (((which == 0) ? a_acc : b_acc) < n && k < max) begin
      @(posedge clk); #2; k++;
    end
    check(tag, 32'(k < max), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k = 0;
    do begin
      @(posedge clk); #2; k++;
    end while (!(grant == 2'b00 && !a_req && !b_req && cq.size() == 0) && k < max);
    check(tag, 32'(k < max), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g_bad, bad_burst, k;
    reset = 1'b0;
    a_req = 0; a_rgb = 24'h123456; b_req = 0; b_yuv = 8'h3c;
    cte_busy = 0; cte_out_valid = 0; cte_rgb_out = 0; cte_yuv_out = 0;
    viol = 0; core_gap = 0;
    clr_counts();
    repeat (3) @(posedge clk);
    #2;
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_op", 32'(cte_op_mode), 32'd0);
    check("rst_outs", 32'({a_ready, b_ready, a_yuv_valid, b_rgb_valid, cte_in_en, a_yuv, cte_yuv_in}), 32'd0);
    reset = 1'b1;

    // A only, 4 pixels
    clr_counts(); a_left = 4; a_mode = 3;
    wait_cnt("t2_acc_wait", 0, 4, 200);
    wait_idle("t2_idle_wait", 200);
    check("t2_a_acc", 32'(a_acc), 32'd4);
    check("t2_a_val", 32'(a_val), 32'd8);
    check("t2_b_val", 32'(b_val), 32'd0);
    check("t2_op", 32'(cte_op_mode), 32'd1);
    check("t2_grant", 32'(grant), 32'd0);

    // busy for exactly 3 cycles mid-RUN
    clr_counts(); a_left = 6; a_mode = 3;
    wait_cnt("t4_acc_wait2", 0, 2, 200);
    busy_mode = 2; busy_cnt = 3;
    wait_cnt("t4_acc_wait6", 0, 6, 200);
    wait_idle("t4_idle_wait", 200);
    busy_mode = 0;
    check("t4_a_acc", 32'(a_acc), 32'd6);
    check("t4_a_val", 32'(a_val), 32'd12);
    check("t4_busy_cycles", 32'(busy_lo), 32'd3);

    // A drops req mid-group: grant held until the group completes
    clr_counts(); a_left = 1; a_mode = 3;
    wait_cnt("t5_acc_wait1", 0, 1, 200);
    g_bad = 0;
    repeat (12) begin
      @(posedge clk); #2;
      if (grant != 2'b01) g_bad++;
    end
    check("t5_hold_grant", 32'(g_bad), 32'd0);
    a_left = 1;
    wait_cnt("t5_acc_wait2", 0, 2, 200);
    wait_idle("t5_idle_wait", 200);
    check("t5_a_acc", 32'(a_acc), 32'd2);
    check("t5_a_val", 32'(a_val), 32'd4);

    // randomized traffic on both channels
    clr_counts(); a_mode = 2; b_mode = 2; busy_mode = 1;
    repeat (3000) @(posedge clk);
    #2;
    a_mode = 4; b_mode = 4; busy_mode = 0;
    wait_idle("rnd_idle_wait", 600);
    check("rnd_err", 32'(err), 32'd0);
    check("rnd_a_active", 32'(a_acc > 0), 32'd1);
    check("rnd_b_active", 32'(b_acc > 0), 32'd1);
    check("rnd_a_results", 32'(a_val), 32'(2 * a_acc));
    check("rnd_b_whole_groups", 32'(b_acc % 4), 32'd0);
    check("rnd_b_results", 32'(b_val), 32'(b_acc / 2));
    check("rnd_exp_left", 32'(exp_a.size() + exp_b.size()), 32'd0);
    bad_burst = 0;
    for (int i = 0; i < glog.size(); i++)
      if (gacc[i] > ((glog[i] == 2'b01) ? 2 * BURST : 4 * BURST)) bad_burst++;
    check("rnd_burst_limit", 32'(bad_burst), 32'd0);

    // asynchronous reset mid-stream, then both channels from reset
    clr_counts(); a_mode = 1; b_mode = 1;
    repeat (20) @(posedge clk);
    #3; reset = 1'b0; #1;
    check("ar_grant", 32'(grant), 32'd0);
    check("ar_err", 32'(err), 32'd0);
    check("ar_op", 32'(cte_op_mode), 32'd0);
    check("ar_outs", 32'({a_ready, b_ready, a_yuv_valid, b_rgb_valid, cte_in_en, cte_yuv_in}), 32'd0);
    repeat (2) @(posedge clk);
    #2; clr_counts(); reset = 1'b1;
    k = 0;
    while (glog.size() < 3 && k < 1000) begin @(posedge clk); #2; k++; end
    check("t3_three_grants", 32'(glog.size() >= 3), 32'd1);
    if (glog.size() >= 3) begin
      check("t3_first_owner", 32'(glog[0]), 32'd1);
      check("t3_a_burst", 32'(gacc[0]), 32'(2 * BURST));
      check("t3_second_owner", 32'(glog[1]), 32'd2);
      check("t3_b_burst", 32'(gacc[1]), 32'(4 * BURST));
      check("t3_third_owner", 32'(glog[2]), 32'd1);
    end
    a_mode = 4; b_mode = 4;
    wait_idle("t3_idle_wait", 600);
    check("t3_err", 32'(err), 32'd0);

    // drain timeout, then a stray output in IDLE
    clr_counts(); core_hold = 1'b1; a_left = 2; a_mode = 3;
    wait_cnt("t6_acc_wait", 0, 2, 200);
    k = 0;
    while (!err && k < 60) begin @(posedge clk); #2; k++; end
    check("t6_timeout_latency", 32'(k >= DRAIN_MAX - 1 && k <= DRAIN_MAX + 2), 32'd1);
    check("t6_err", 32'(err), 32'd1);
    @(posedge clk); #2;
    check("t6_grant", 32'(grant), 32'd0);
    core_hold = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    check("t6_stray_dropped", 32'(a_val), 32'd0);
    check("t6_err_sticky", 32'(err), 32'd1);

    check("protocol_viol", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
